// File: rtl/pwm_pkg.sv
// Shared constants, command-byte layout and FSM encoding for the PWM configuration controller.
package pwm_pkg;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned CMD_WRITE = 7;

   localparam logic [ADDR_W-1:0] ADDR_ENABLE = 4'hC;
   localparam logic [ADDR_W-1:0] ADDR_COMMIT = 4'hD;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'hE;
   localparam logic [ADDR_W-1:0] ADDR_ID     = 4'hF;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_WR   = 3'd2;
   localparam logic [2:0] ST_RD   = 3'd3;
   localparam logic [2:0] ST_DROP = 3'd4;

   typedef struct packed {
      logic              wr;
      logic [2:0]        rsvd;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

   // Duty registers occupy 0..nch-1; 0xC..0xF are the fixed control registers.
   function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int unsigned nch);
      return (32'(addr) < nch) || (addr >= ADDR_ENABLE);
   endfunction

endpackage

// File: rtl/pwm_shadow_bank.sv
// Shadow/active duty and enable registers; shadow is copied to active on a period boundary.
module pwm_shadow_bank
   import pwm_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              commit_req,
   input  logic              period_end,
   output logic [NCH*DW-1:0] duty_sh,
   output logic [NCH-1:0]    enable_sh,
   output logic [NCH*DW-1:0] duty,
   output logic [NCH-1:0]    enable,
   output logic              commit_pend
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_sh     <= '0;
         enable_sh   <= '0;
         duty        <= '0;
         enable      <= '0;
         commit_pend <= 1'b0;
      end else begin
         // Active samples the pre-edge shadow, so a coincident write lands in the next period.
         if (period_end && commit_pend) begin
            duty   <= duty_sh;
            enable <= enable_sh;
         end
         // A request arriving on the commit cycle itself waits for the next boundary.
         commit_pend <= commit_req | (commit_pend & ~period_end);
         if (wr_en) begin
            for (int n = 0; n < int'(NCH); n++) begin
               if (wr_addr == ADDR_W'(n)) duty_sh[n*DW +: DW] <= wr_data;
            end
            if (wr_addr == ADDR_ENABLE) enable_sh <= NCH'(wr_data);
         end
      end
   end

endmodule

// File: rtl/pwm_cfg_controller.sv
// SPI frame decoder for the PWM IO expander: write/read register frames, sticky error, commit control.
module pwm_cfg_controller
   import pwm_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = 8,
   parameter logic [7:0]  ID  = 8'hA5
) (
   input  logic              MainCLK,
   input  logic              RST,
   input  logic              cs_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_load,
   output logic [7:0]        tx_data,
   input  logic              period_end,
   output logic [NCH*DW-1:0] duty_o,
   output logic [NCH-1:0]    enable_o,
   output logic              commit_pend,
   output logic              frame_err
);

   logic [2:0]        state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic              cs_prev;
   logic              err_nx, load_nx;
   logic [7:0]        txd_nx;

   logic              wr_en_c, commit_req_c, rd_fire_c, rd_ok_c;
   logic [ADDR_W-1:0] rd_addr_c;
   logic [7:0]        rd_data_c;
   logic [NCH*DW-1:0] duty_sh;
   logic [NCH-1:0]    enable_sh;
   cmd_t              cmd_c;

   assign cmd_c = cmd_t'(rx_data);

   pwm_shadow_bank #(
      .NCH (NCH),
      .DW  (DW)
   ) u_bank (
      .clk         (MainCLK),
      .rst         (RST),
      .wr_en       (wr_en_c),
      .wr_addr     (addr),
      .wr_data     (DW'(rx_data)),
      .commit_req  (commit_req_c),
      .period_end  (period_end),
      .duty_sh     (duty_sh),
      .enable_sh   (enable_sh),
      .duty        (duty_o),
      .enable      (enable_o),
      .commit_pend (commit_pend)
   );

   // Read mux: the first read uses the command byte's address, later ones the running address.
   always_comb begin : read_mux
      rd_addr_c = (state == ST_CMD) ? cmd_c.addr : addr;
      rd_ok_c   = addr_valid(rd_addr_c, NCH);
      rd_data_c = 8'h00;
      for (int n = 0; n < int'(NCH); n++) begin
         if (rd_addr_c == ADDR_W'(n)) rd_data_c = 8'(duty_sh[n*DW +: DW]);
      end
      case (rd_addr_c)
         ADDR_ENABLE: rd_data_c = 8'(enable_sh);
         ADDR_STATUS: rd_data_c = {6'b0, commit_pend, frame_err};
         ADDR_ID:     rd_data_c = ID;
         default:     ;
      endcase
   end

   always_comb begin : next_state
      state_nx     = state;
      addr_nx      = addr;
      err_nx       = frame_err;
      load_nx      = 1'b0;
      txd_nx       = tx_data;
      wr_en_c      = 1'b0;
      commit_req_c = 1'b0;
      rd_fire_c    = 1'b0;
      if (!cs_active) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (!cs_prev) state_nx = ST_CMD;
            ST_CMD: begin
               if (rx_valid) begin
                  if (cmd_c.rsvd != 3'b000 || !addr_valid(cmd_c.addr, NCH)) begin
                     err_nx   = 1'b1;
                     state_nx = ST_DROP;
                  end else if (rx_data[CMD_WRITE]) begin
                     state_nx = ST_WR;
                     addr_nx  = cmd_c.addr;
                  end else begin
                     state_nx  = ST_RD;
                     rd_fire_c = 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (rx_valid) begin
                  if (!addr_valid(addr, NCH)) begin
                     err_nx   = 1'b1;
                     state_nx = ST_DROP;
                  end else begin
                     wr_en_c      = 1'b1;
                     commit_req_c = (addr == ADDR_COMMIT);
                     addr_nx      = addr + 4'd1;
                  end
               end
            end
            ST_RD:   if (rx_valid) rd_fire_c = 1'b1;
            ST_DROP: ;
            default: state_nx = ST_IDLE;
         endcase
      end
      // STATUS value is captured before its clear takes effect.
      if (rd_fire_c) begin
         load_nx = 1'b1;
         txd_nx  = rd_data_c;
         addr_nx = rd_addr_c + 4'd1;
         if (!rd_ok_c) err_nx = 1'b1;
         else if (rd_addr_c == ADDR_STATUS) err_nx = 1'b0;
      end
   end

   always_ff @(posedge MainCLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         addr      <= '0;
         cs_prev   <= 1'b0;
         frame_err <= 1'b0;
         tx_load   <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         state     <= state_nx;
         addr      <= addr_nx;
         cs_prev   <= cs_active;
         frame_err <= err_nx;
         tx_load   <= load_nx;
         tx_data   <= txd_nx;
      end
   end

endmodule

// File: tb/tb_pwm_cfg_controller.sv
// Bench for pwm_cfg_controller: frame-level register model checked every cycle, plus literal pins.
module tb_pwm_cfg_controller;

   localparam int NCH = 4;
   localparam int M_IDLE = 0, M_CMD = 1, M_WR = 2, M_RD = 3, M_DROP = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cs, rxv, pe;
   logic [7:0]       rxd;
   logic             tx_load;
   logic [7:0]       tx_data;
   logic [NCH*8-1:0] duty;
   logic [NCH-1:0]   enable;
   logic             pend, err;

   int  n_chk = 0, n_fail = 0;
   bit  chk_on = 1'b0;

   int  m_sh[NCH], m_act[NCH];
   int  m_sh_en, m_act_en, m_tx, m_mode, m_addr;
   bit  m_pend, m_err, m_load, m_cs_prev;

   always #5 clk = ~clk;

   pwm_cfg_controller #(.NCH(NCH), .DW(8), .ID(8'hA5)) dut (
      .MainCLK     (clk),
      .RST         (rst),
      .cs_active   (cs),
      .rx_valid    (rxv),
      .rx_data     (rxd),
      .tx_load     (tx_load),
      .tx_data     (tx_data),
      .period_end  (pe),
      .duty_o      (duty),
      .enable_o    (enable),
      .commit_pend (pend),
      .frame_err   (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ok_addr(input int a);
      return (a < NCH) || (a >= 12);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_sh[i]  = 0;
         m_act[i] = 0;
      end
      m_sh_en = 0; m_act_en = 0; m_tx = 0; m_mode = M_IDLE; m_addr = 0;
      m_pend = 0; m_err = 0; m_load = 0; m_cs_prev = 0;
   endtask

   task automatic model_read(input int a, input bit pend_old);
      m_load = 1;
      if (a < NCH)      m_tx = m_sh[a];
      else if (a == 12) m_tx = m_sh_en;
      else if (a == 13) m_tx = 0;
      else if (a == 14) m_tx = (pend_old ? 2 : 0) + (m_err ? 1 : 0);
      else if (a == 15) m_tx = 'hA5;
      else begin
         m_tx  = 0;
         m_err = 1;
      end
      if (a == 14) m_err = 0;
      m_addr = (a + 1) % 16;
   endtask

   // One clock of the register map as seen from the SPI side and the PWM boundary.
   task automatic model_step(input bit c, input bit v, input int d, input bit p);
      bit pend_old;
      pend_old = m_pend;
      m_load   = 0;
      if (p && m_pend) begin
         for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
         m_act_en = m_sh_en;
         m_pend   = 0;
      end
      if (!c) m_mode = M_IDLE;
      else begin
         case (m_mode)
            M_IDLE: if (!m_cs_prev) m_mode = M_CMD;
            M_CMD: if (v) begin
               if (((d >> 4) & 7) != 0 || !ok_addr(d & 15)) begin
                  m_err = 1; m_mode = M_DROP;
               end else if ((d & 128) != 0) begin
                  m_mode = M_WR; m_addr = d & 15;
               end else begin
                  m_mode = M_RD; model_read(d & 15, pend_old);
               end
            end
            M_WR: if (v) begin
               if (!ok_addr(m_addr)) begin
                  m_err = 1; m_mode = M_DROP;
               end else begin
                  if (m_addr < NCH)      m_sh[m_addr] = d;
                  else if (m_addr == 12) m_sh_en = d & ((1 << NCH) - 1);
                  else if (m_addr == 13) m_pend = 1;
                  m_addr = (m_addr + 1) % 16;
               end
            end
            M_RD: if (v) model_read(m_addr, pend_old);
            default: ;
         endcase
      end
      m_cs_prev = c;
   endtask

   task automatic tick();
      bit c, v, p;
      int d;
      c = cs; v = rxv; p = pe; d = int'(rxd);
      @(posedge clk);
      model_step(c, v, d, p);
      #1;
   endtask

   task automatic pulse_pe();
      pe = 1'b1; tick(); pe = 1'b0; tick();
   endtask

   task automatic frame(input int b[4], input int n, input int pe_at);
      cs = 1'b1; tick();
      for (int i = 0; i < n; i++) begin
         rxv = 1'b1; rxd = 8'(b[i]); pe = (i == pe_at);
         tick();
         rxv = 1'b0; pe = 1'b0;
         tick(); tick();
      end
      cs = 1'b0; tick(); tick();
   endtask

   always @(negedge clk) begin
      logic [NCH*8-1:0] e;
      if (chk_on && !rst) begin
         for (int i = 0; i < NCH; i++) e[i*8 +: 8] = 8'(m_act[i]);
         check("duty_o", 64'(duty), 64'(e));
         check("enable_o", 64'(enable), 64'(m_act_en));
         check("commit_pend", 64'(pend), 64'(m_pend));
         check("frame_err", 64'(err), 64'(m_err));
         check("tx_data", 64'(tx_data), 64'(m_tx));
         check("tx_load", 64'(tx_load), 64'(m_load));
      end
   end

   initial begin
      rst = 1'b1; cs = 1'b0; rxv = 1'b0; pe = 1'b0; rxd = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1'b1;
      tick();
      check("rst_duty", 64'(duty), 64'h0);
      check("rst_tx", 64'(tx_data), 64'h0);

      // Write ch0/ch1, commit, then period boundary.
      frame('{'h80, 'h40, 'h80, 0}, 3, -1);
      frame('{'h8D, 'h00, 0, 0}, 2, -1);
      check("t1_pend_set", 64'(pend), 64'h1);
      check("t1_duty_before", 64'(duty), 64'h0);
      pe = 1'b1; tick(); pe = 1'b0;
      check("t1_duty_after", 64'(duty), 64'h8040);
      check("t1_pend_clr", 64'(pend), 64'h0);
      tick();

      // Shadow write without commit never reaches the outputs.
      frame('{'h83, 'h77, 0, 0}, 2, -1);
      repeat (3) pulse_pe();
      check("t2_duty_hold", 64'(duty), 64'h8040);

      // Reads: STATUS then ID; then running into an invalid address.
      frame('{'h0E, 'h00, 0, 0}, 2, -1);
      check("t3_id", 64'(tx_data), 64'hA5);
      frame('{'h03, 'h00, 0, 0}, 2, -1);
      check("t3_inv_data", 64'(tx_data), 64'h00);
      check("t3_inv_err", 64'(err), 64'h1);
      frame('{'h0E, 0, 0, 0}, 1, -1);
      check("t3_status", 64'(tx_data), 64'h01);
      check("t3_err_clr", 64'(err), 64'h0);

      // Reserved command bit: error, data dropped.
      frame('{'h90, 'h12, 'h34, 0}, 3, -1);
      check("t4_err", 64'(err), 64'h1);
      frame('{'h0E, 0, 0, 0}, 1, -1);
      check("t4_status", 64'(tx_data), 64'h01);
      check("t4_err_clr", 64'(err), 64'h0);
      frame('{'h01, 0, 0, 0}, 1, -1);
      check("t4_ch1_kept", 64'(tx_data), 64'h80);

      // Frame aborted after the command byte, then a clean single write.
      cs = 1'b1; tick();
      rxv = 1'b1; rxd = 8'h80; tick();
      rxv = 1'b0; tick();
      cs = 1'b0; tick(); tick();
      frame('{'h81, 'h33, 0, 0}, 2, -1);
      frame('{'h00, 'h00, 0, 0}, 2, -1);
      check("t5_ch1", 64'(tx_data), 64'h33);
      frame('{'h00, 0, 0, 0}, 1, -1);
      check("t5_ch0", 64'(tx_data), 64'h40);

      // COMMIT write on a boundary with nothing pending waits for the next boundary.
      frame('{'h80, 'h11, 0, 0}, 2, -1);
      frame('{'h8C, 'h0F, 0, 0}, 2, -1);
      frame('{'h8D, 'h00, 0, 0}, 2, 1);
      check("t6_not_yet", 64'(duty), 64'h8040);
      check("t6_pend", 64'(pend), 64'h1);
      pulse_pe();
      check("t6_duty", 64'(duty), 64'h7700_3311);
      check("t6_enable", 64'(enable), 64'hF);

      // Shadow write coincident with commit: active takes the old shadow.
      frame('{'h8D, 'h00, 0, 0}, 2, -1);
      frame('{'h80, 'h22, 0, 0}, 2, -1);
      frame('{'h80, 'h55, 0, 0}, 2, 1);
      check("t6_old_shadow", 64'(duty[7:0]), 64'h22);
      frame('{'h8D, 'h00, 0, 0}, 2, -1);
      pulse_pe();
      check("t6_new_shadow", 64'(duty[7:0]), 64'h55);

      // COMMIT write on a boundary while pending: commits and re-arms.
      frame('{'h8D, 'h00, 0, 0}, 2, -1);
      frame('{'h81, 'h66, 0, 0}, 2, -1);
      frame('{'h8D, 'h00, 0, 0}, 2, 1);
      check("t6_ch1_commit", 64'(duty[15:8]), 64'h66);
      check("t6_rearm", 64'(pend), 64'h1);

      // Asynchronous reset in the middle of a frame.
      cs = 1'b1; tick();
      rxv = 1'b1; rxd = 8'h80; tick();
      rxv = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_duty", 64'(duty), 64'h0);
      check("arst_enable", 64'(enable), 64'h0);
      check("arst_pend", 64'(pend), 64'h0);
      check("arst_tx", 64'(tx_data), 64'h0);
      check("arst_load", 64'(tx_load), 64'h0);
      model_reset();
      cs = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick(); tick();
      check("post_rst_err", 64'(err), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
